load_store_unit: RTL

Memory-access controller between the CPU datapath and the 64-bit byte-addressed data memory (`Memoria64`). It accepts one load or store request at a time through a valid/ready handshake and sizes it to byte, half, word or doubleword. Loads return a sign- or zero-extended result. Sub-doubleword stores run as a read-modify-write, because the memory always writes all 8 bytes at the write address.

---
 rtl/load_store_unit.sv | 130 +++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit for the 64-bit data memory: sized, extended loads and
// read-modify-write sub-doubleword stores behind a valid/ready handshake.
module load_store_unit #(
    parameter int RD_LAT = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic [63:0] mem_raddress,
    output logic [63:0] mem_waddress,
    output logic [63:0] mem_datain,
    output logic        mem_wr,
    input  logic [63:0] mem_dataout
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        RESP
    } stateT;

    stateT       state;
    stateT       nextState;
    logic [2:0]  waitCnt;
    logic        isWrite;
    logic [1:0]  opSize;
    logic        isSigned;
    logic [63:0] wdataReg;
    logic        accept;
    logic        fullStore;

    function automatic logic [63:0] extendLoad(
        input logic [63:0] d,
        input logic [1:0]  size,
        input logic        sgn
    );
        logic [63:0] r;
        unique case (size)
            2'b00:   r = {{56{sgn & d[7]}}, d[7:0]};
            2'b01:   r = {{48{sgn & d[15]}}, d[15:0]};
            2'b10:   r = {{32{sgn & d[31]}}, d[31:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    // Bytes above the store size keep the value just read back.
    function automatic logic [63:0] mergeStore(
        input logic [63:0] old,
        input logic [63:0] wd,
        input logic [1:0]  size
    );
        logic [63:0] r;
        unique case (size)
            2'b00:   r = {old[63:8], wd[7:0]};
            2'b01:   r = {old[63:16], wd[15:0]};
            2'b10:   r = {old[63:32], wd[31:0]};
            default: r = wd;
        endcase
        return r;
    endfunction

    assign req_ready  = (state == IDLE) & ~Reset;
    assign accept     = req_valid & req_ready;
    assign fullStore  = req_write & (req_size == 2'b11);
    assign mem_wr     = (state == WRITE) & ~Reset;
    assign resp_valid = (state == RESP) & ~Reset;

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: begin
                if (accept) nextState = fullStore ? WRITE : READ;
            end
            READ: begin
                if (waitCnt == 3'd0) nextState = isWrite ? WRITE : RESP;
            end
            WRITE:   nextState = RESP;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= IDLE;
            waitCnt      <= 3'd0;
            isWrite      <= 1'b0;
            opSize       <= 2'b00;
            isSigned     <= 1'b0;
            wdataReg     <= 64'd0;
            resp_rdata   <= 64'd0;
            mem_raddress <= 64'd0;
            mem_waddress <= 64'd0;
            mem_datain   <= 64'd0;
        end else begin
            state <= nextState;
            if (accept) begin
                isWrite      <= req_write;
                opSize       <= req_size;
                isSigned     <= req_signed;
                wdataReg     <= req_wdata;
                mem_raddress <= req_addr;
                mem_waddress <= req_addr;
                waitCnt      <= 3'(RD_LAT);
                if (fullStore) mem_datain <= req_wdata;
            end
            // Final read cycle: memory data is valid, capture it sized.
            if (state == READ) begin
                if (waitCnt != 3'd0) begin
                    waitCnt <= waitCnt - 3'd1;
                end else if (isWrite) begin
                    mem_datain <= mergeStore(mem_dataout, wdataReg, opSize);
                end else begin
                    resp_rdata <= extendLoad(mem_dataout, opSize, isSigned);
                end
            end
            if (state == WRITE) resp_rdata <= 64'd0;
        end
    end

endmodule
